krz_sys_initiator: RTL and testbench

//  Initiator for the Kronos system bus (sys_adr/sys_dat/sys_stb/sys_we/sys_ack): turns one client

---
 rtl/krz_pkg.sv | 17 +
 rtl/krz_sys_initiator.sv | 110 +++++++++++
 tb/tb_krz_sys_initiator.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/krz_pkg.sv
// Shared Kronos system-bus types.
//   sys_state_e : initiator FSM states (IDLE -> BUS -> RESP -> IDLE)
//   sys_req_t   : one client request as captured onto the bus; also used by krz_intercon
package krz_pkg;

   localparam int SYS_AWIDTH = 24;

   typedef enum logic [1:0] {SYS_IDLE, SYS_BUS, SYS_RESP} sys_state_e;

   typedef struct packed {
      logic [SYS_AWIDTH-1:0] addr;
      logic [31:0]           wdata;
      logic                  we;
      logic [3:0]            mask;
   } sys_req_t;

endpackage

// File: rtl/krz_sys_initiator.sv
// Kronos system-bus initiator: one client request (valid/ready) becomes exactly one
// strobe-until-ack bus transaction, answered by one response (valid/ready).
// A bus timeout turns a missing responder into an error response instead of a hang.
// Ports:
//   clk, RSTN                     clock, async active-low reset
//   req_valid/req_ready           client request handshake
//   req_addr/wdata/we/mask        request payload (byte address, write data, dir, byte enables)
//   rsp_valid/rsp_ready           response handshake, rsp_valid held until accepted
//   rsp_rdata/rsp_err             read data (0 for writes/errors), timeout flag
//   sys_adr/dat/sel/we/stb_o      bus request, qualified by sys_stb_o only
//   sys_dat_i/sys_ack_i           bus read data and acknowledge
module krz_sys_initiator
   import krz_pkg::*;
#(
   parameter int AWIDTH  = 24,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              RSTN,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [AWIDTH-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic              req_we,
   input  logic [3:0]        req_mask,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [AWIDTH-1:0] sys_adr_o,
   output logic [31:0]       sys_dat_o,
   output logic [3:0]        sys_sel_o,
   output logic              sys_we_o,
   output logic              sys_stb_o,
   input  logic [31:0]       sys_dat_i,
   input  logic              sys_ack_i
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   sys_state_e state;
   sys_req_t   req_q;
   logic       accept;
   logic       timeout_hit;

   assign req_ready = (state == SYS_IDLE);
   assign rsp_valid = (state == SYS_RESP);
   assign accept    = req_valid & req_ready;

   // Strobe drops in the ack cycle itself: a registered-ack responder never
   // sees a second strobe for the same transaction.
   assign sys_stb_o = (state == SYS_BUS) & ~sys_ack_i;

   assign sys_adr_o = AWIDTH'(req_q.addr);
   assign sys_dat_o = req_q.wdata;
   assign sys_sel_o = req_q.mask;
   assign sys_we_o  = req_q.we;

   generate
      if (TIMEOUT > 0) begin : g_to
         logic [CW-1:0] cnt;
         always_ff @(posedge clk or negedge RSTN) begin
            if (!RSTN)                              cnt <= '0;
            else if (accept)                        cnt <= '0;
            else if (state == SYS_BUS && !sys_ack_i) cnt <= cnt + CW'(1);
         end
         // Last strobe cycle without ack; ack in the same cycle still wins in the FSM.
         assign timeout_hit = (state == SYS_BUS) && (cnt == CW'(TIMEOUT - 1));
      end else begin : g_no_to
         assign timeout_hit = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         state     <= SYS_IDLE;
         req_q     <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            SYS_IDLE: begin
               if (req_valid) begin
                  req_q.addr  <= SYS_AWIDTH'(req_addr);
                  req_q.wdata <= req_wdata;
                  req_q.we    <= req_we;
                  req_q.mask  <= req_mask;
                  state       <= SYS_BUS;
               end
            end
            SYS_BUS: begin
               if (sys_ack_i) begin
                  rsp_rdata <= req_q.we ? 32'h0 : sys_dat_i;
                  rsp_err   <= 1'b0;
                  state     <= SYS_RESP;
               end else if (timeout_hit) begin
                  rsp_rdata <= 32'h0;
                  rsp_err   <= 1'b1;
                  state     <= SYS_RESP;
               end
            end
            SYS_RESP: begin
               if (rsp_ready) state <= SYS_IDLE;
            end
            default: state <= SYS_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_krz_sys_initiator.sv
// Bench for krz_sys_initiator: a registered-ack responder with programmable wait
// states drives the bus side; expected responses come from a plain array model.
module tb_krz_sys_initiator;

   logic        clk = 1'b0;
   logic        RSTN = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [23:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        req_we = 1'b0;
   logic [3:0]  req_mask = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [23:0] sys_adr_o;
   logic [31:0] sys_dat_o;
   logic [3:0]  sys_sel_o;
   logic        sys_we_o;
   logic        sys_stb_o;
   logic [31:0] sys_dat_i;
   logic        sys_ack_i;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   krz_sys_initiator #(.AWIDTH(24), .TIMEOUT(16)) dut (
      .clk(clk), .RSTN(RSTN),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_we(req_we), .req_mask(req_mask),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .sys_adr_o(sys_adr_o), .sys_dat_o(sys_dat_o), .sys_sel_o(sys_sel_o),
      .sys_we_o(sys_we_o), .sys_stb_o(sys_stb_o), .sys_dat_i(sys_dat_i), .sys_ack_i(sys_ack_i)
   );

   // ---------------- responder (registered ack, ws wait states) ----------------
   int          ws = 0;
   bit          resp_en = 1'b1;
   logic        stray_ack = 1'b0;
   logic        ack_r;
   logic [31:0] dat_r;
   int          wcnt;
   int          wr_total = 0;
   logic [31:0] mem [64];

   assign sys_ack_i = ack_r | stray_ack;
   assign sys_dat_i = dat_r;

   always @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         ack_r <= 1'b0;
         dat_r <= '0;
         wcnt  <= 0;
         for (int i = 0; i < 64; i++) mem[i] <= 32'(i);
      end else if (sys_stb_o && resp_en) begin
         if (wcnt == ws) begin
            ack_r <= 1'b1;
            wcnt  <= 0;
            if (sys_we_o) begin
               for (int b = 0; b < 4; b++)
                  if (sys_sel_o[b]) mem[sys_adr_o[7:2]][8*b +: 8] <= sys_dat_o[8*b +: 8];
               wr_total <= wr_total + 1;
            end else begin
               dat_r <= mem[sys_adr_o[7:2]];
            end
         end else begin
            wcnt <= wcnt + 1;
         end
      end else begin
         ack_r <= 1'b0;
      end
   end

   // ---------------- bus monitor ----------------
   int          stb_total = 0;
   int          hold_bad = 0;
   logic [23:0] exp_adr = '0;
   logic [31:0] exp_dat = '0;
   logic        exp_we = 1'b0;
   logic [3:0]  exp_sel = '0;

   always @(negedge clk) begin
      if (sys_stb_o) begin
         stb_total <= stb_total + 1;
         if (sys_adr_o !== exp_adr || sys_dat_o !== exp_dat || sys_we_o !== exp_we || sys_sel_o !== exp_sel)
            hold_bad <= hold_bad + 1;
      end
   end

   // ---------------- reference model ----------------
   logic [31:0] ref_mem [64];

   task automatic ref_init();
      for (int i = 0; i < 64; i++) ref_mem[i] = 32'(i);
   endtask

   task automatic ref_write(input logic [23:0] a, input logic [31:0] d, input logic [3:0] m);
      for (int b = 0; b < 4; b++)
         if (m[b]) ref_mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
   endtask

   // ---------------- drivers ----------------
   task automatic start_req(input logic [23:0] a, input logic [31:0] d, input logic we, input logic [3:0] m);
      int n;
      @(negedge clk);
      req_addr = a; req_wdata = d; req_we = we; req_mask = m; req_valid = 1'b1;
      exp_adr = a; exp_dat = d; exp_we = we; exp_sel = m;
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   // lat = negedges from the accept edge until rsp_valid is seen
   task automatic wait_rsp(output int lat, output bit to);
      lat = 0;
      do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 100);
      to = !rsp_valid;
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #12;
      tests++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || sys_stb_o !== 1'b0 || rsp_rdata !== 32'h0 ||
          rsp_err !== 1'b0 || sys_adr_o !== 24'h0 || sys_dat_o !== 32'h0 || sys_sel_o !== 4'h0 || sys_we_o !== 1'b0) begin
         fails++;
         $display("FAIL reset: ready=%b valid=%b stb=%b rdata=%h err=%b adr=%h dat=%h sel=%h we=%b, required ready=1 rest 0",
                  req_ready, rsp_valid, sys_stb_o, rsp_rdata, rsp_err, sys_adr_o, sys_dat_o, sys_sel_o, sys_we_o);
      end
      @(negedge clk);
      RSTN = 1'b1;
      ref_init();
   endtask

   task automatic test_read();
      int s0, lat; bit to;
      resp_en = 1; ws = 0;
      s0 = stb_total;
      start_req(24'h000004, 32'h0, 1'b0, 4'h0);
      wait_rsp(lat, to);
      tests++;
      if (to !== 1'b0 || rsp_rdata !== ref_mem[1] || rsp_err !== 1'b0) begin
         fails++; $display("FAIL read_rsp: to=%b rdata=%h err=%b, required to=0 rdata=%h err=0", to, rsp_rdata, rsp_err, ref_mem[1]);
      end
      tests++;
      if (stb_total - s0 != 1 || lat != 3) begin
         fails++; $display("FAIL read_timing: stb=%0d lat=%0d, required stb=1 lat=3", stb_total - s0, lat);
      end
      finish_rsp();
   endtask

   task automatic test_write();
      int s0, w0, lat; bit to;
      resp_en = 1; ws = 0;
      s0 = stb_total; w0 = wr_total;
      start_req(24'h000000, 32'h1, 1'b1, 4'hF);
      ref_write(24'h000000, 32'h1, 4'hF);
      wait_rsp(lat, to);
      tests++;
      if (to !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
         fails++; $display("FAIL write_rsp: to=%b rdata=%h err=%b, required to=0 rdata=0 err=0", to, rsp_rdata, rsp_err);
      end
      finish_rsp();
      @(negedge clk);
      tests++;
      if (wr_total - w0 != 1 || stb_total - s0 != 1 || mem[0] !== ref_mem[0]) begin
         fails++; $display("FAIL write_once: writes=%0d stb=%0d mem0=%h, required writes=1 stb=1 mem0=%h",
                           wr_total - w0, stb_total - s0, mem[0], ref_mem[0]);
      end
   endtask

   task automatic test_wait_states();
      int s0, h0, lat; bit to;
      resp_en = 1; ws = 5;
      s0 = stb_total; h0 = hold_bad;
      start_req(24'h000008, 32'hDEAD_BEEF, 1'b0, 4'h5);
      wait_rsp(lat, to);
      tests++;
      if (to !== 1'b0 || rsp_rdata !== ref_mem[2] || rsp_err !== 1'b0) begin
         fails++; $display("FAIL wait_rsp: to=%b rdata=%h err=%b, required rdata=%h err=0", to, rsp_rdata, rsp_err, ref_mem[2]);
      end
      tests++;
      if (stb_total - s0 != 6 || hold_bad != h0 || lat != 8) begin
         fails++; $display("FAIL wait_hold: stb=%0d unstable=%0d lat=%0d, required stb=6 unstable=0 lat=8",
                           stb_total - s0, hold_bad - h0, lat);
      end
      finish_rsp();
   endtask

   task automatic test_timeout();
      int s0, lat; bit to;
      resp_en = 0; ws = 0;
      s0 = stb_total;
      start_req(24'h0000F0, 32'h1234_5678, 1'b0, 4'hF);
      wait_rsp(lat, to);
      tests++;
      if (to !== 1'b0 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
         fails++; $display("FAIL timeout_rsp: to=%b err=%b rdata=%h, required err=1 rdata=0", to, rsp_err, rsp_rdata);
      end
      tests++;
      if (stb_total - s0 != 16 || lat != 17) begin
         fails++; $display("FAIL timeout_len: stb=%0d lat=%0d, required stb=16 lat=17", stb_total - s0, lat);
      end
      finish_rsp();
      @(negedge clk);
      tests++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         fails++; $display("FAIL timeout_idle: ready=%b valid=%b, required ready=1 valid=0", req_ready, rsp_valid);
      end
      resp_en = 1;
   endtask

   task automatic test_backpressure();
      int s0, lat, bad; bit to;
      resp_en = 1; ws = 0;
      start_req(24'h000004, 32'h0, 1'b0, 4'h0);
      wait_rsp(lat, to);
      s0 = stb_total;
      req_addr = 24'h000010; req_we = 1'b1; req_wdata = 32'hFFFF_FFFF; req_mask = 4'hF; req_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_rdata !== ref_mem[1] || rsp_err !== 1'b0 || req_ready !== 1'b0 || sys_stb_o !== 1'b0)
            bad++;
      end
      tests++;
      if (to !== 1'b0 || bad != 0) begin
         fails++; $display("FAIL backpressure_hold: to=%b bad_cycles=%0d rdata=%h, required 0 bad rdata=%h", to, bad, rsp_rdata, ref_mem[1]);
      end
      req_valid = 1'b0;
      finish_rsp();
      @(negedge clk);
      tests++;
      if (stb_total != s0 || req_ready !== 1'b1 || mem[4] !== ref_mem[4]) begin
         fails++; $display("FAIL backpressure_noaccept: stb=%0d ready=%b mem4=%h, required stb=0 ready=1 mem4=%h",
                           stb_total - s0, req_ready, mem[4], ref_mem[4]);
      end
   endtask

   task automatic test_random();
      int lat, s0, bad; bit to;
      logic [23:0] a; logic [31:0] d, exp_rd; logic we; logic [3:0] m; logic exp_err; int exp_stb;
      bad = 0;
      for (int k = 0; k < 24; k++) begin
         a = 24'($urandom); d = $urandom; we = 1'($urandom); m = 4'($urandom);
         ws = $urandom_range(0, 5);
         resp_en = ($urandom_range(0, 7) != 0);
         if (!resp_en) begin
            exp_rd = 0; exp_err = 1; exp_stb = 16;
         end else begin
            exp_err = 0; exp_stb = ws + 1;
            exp_rd = we ? 32'h0 : ref_mem[a[7:2]];
            if (we) ref_write(a, d, m);
         end
         s0 = stb_total;
         start_req(a, d, we, m);
         wait_rsp(lat, to);
         tests++;
         if (to !== 1'b0 || rsp_rdata !== exp_rd || rsp_err !== exp_err || stb_total - s0 != exp_stb) begin
            fails++; bad++;
            $display("FAIL random[%0d]: to=%b rdata=%h err=%b stb=%0d, required rdata=%h err=%b stb=%0d",
                     k, to, rsp_rdata, rsp_err, stb_total - s0, exp_rd, exp_err, exp_stb);
         end
         finish_rsp();
      end
      resp_en = 1;
   endtask

   task automatic test_reset_mid();
      int s0, lat; bit to;
      resp_en = 0; ws = 0;
      start_req(24'h000020, 32'hCAFE_F00D, 1'b1, 4'hF);
      repeat (3) @(negedge clk);
      #2 RSTN = 1'b0;
      #1;
      tests++;
      if (sys_stb_o !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || sys_adr_o !== 24'h0 || sys_we_o !== 1'b0) begin
         fails++; $display("FAIL reset_mid: stb=%b ready=%b valid=%b adr=%h we=%b, required stb=0 ready=1 valid=0 adr=0 we=0",
                           sys_stb_o, req_ready, rsp_valid, sys_adr_o, sys_we_o);
      end
      @(negedge clk);
      RSTN = 1'b1;
      ref_init();
      resp_en = 1;
      s0 = stb_total;
      @(negedge clk); stray_ack = 1'b1;
      @(negedge clk); stray_ack = 1'b0;
      @(negedge clk);
      tests++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || stb_total != s0) begin
         fails++; $display("FAIL stray_ack: ready=%b valid=%b stb=%0d, required ready=1 valid=0 stb=0", req_ready, rsp_valid, stb_total - s0);
      end
      start_req(24'h00000C, 32'h0, 1'b0, 4'h0);
      wait_rsp(lat, to);
      tests++;
      if (to !== 1'b0 || rsp_rdata !== ref_mem[3] || rsp_err !== 1'b0 || lat != 3) begin
         fails++; $display("FAIL after_reset: to=%b rdata=%h err=%b lat=%0d, required rdata=%h err=0 lat=3",
                           to, rsp_rdata, rsp_err, lat, ref_mem[3]);
      end
      finish_rsp();
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_wait_states();
      test_timeout();
      test_backpressure();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global guard so a wedged handshake still ends the run.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
